// File: rtl/kbd_scancode_decoder_pkg.sv
// Shared types, scan-code constants and set-2 to ASCII lookup tables
// for the keyboard scan-code decoder.
package kbd_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_DEC, ST_EMIT} kbd_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] ascii;
  } kbd_evt_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  // Device-generated bytes that never encode a key.
  localparam logic [5:0][7:0] CTRL_LIST = {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  function automatic logic is_ctrl(input logic [7:0] b);
    is_ctrl = 1'b0;
    for (int i = 0; i < 6; i++)
      if (CTRL_LIST[i] == b) is_ctrl = 1'b1;
  endfunction

  // Unshifted translation; letters come back lowercase.
  function automatic logic [7:0] ascii_base(input logic [7:0] sc);
    case (sc)
      8'h1C: ascii_base = 8'h61;  8'h32: ascii_base = 8'h62;  8'h21: ascii_base = 8'h63;
      8'h23: ascii_base = 8'h64;  8'h24: ascii_base = 8'h65;  8'h2B: ascii_base = 8'h66;
      8'h34: ascii_base = 8'h67;  8'h33: ascii_base = 8'h68;  8'h43: ascii_base = 8'h69;
      8'h3B: ascii_base = 8'h6A;  8'h42: ascii_base = 8'h6B;  8'h4B: ascii_base = 8'h6C;
      8'h3A: ascii_base = 8'h6D;  8'h31: ascii_base = 8'h6E;  8'h44: ascii_base = 8'h6F;
      8'h4D: ascii_base = 8'h70;  8'h15: ascii_base = 8'h71;  8'h2D: ascii_base = 8'h72;
      8'h1B: ascii_base = 8'h73;  8'h2C: ascii_base = 8'h74;  8'h3C: ascii_base = 8'h75;
      8'h2A: ascii_base = 8'h76;  8'h1D: ascii_base = 8'h77;  8'h22: ascii_base = 8'h78;
      8'h35: ascii_base = 8'h79;  8'h1A: ascii_base = 8'h7A;
      8'h45: ascii_base = 8'h30;  8'h16: ascii_base = 8'h31;  8'h1E: ascii_base = 8'h32;
      8'h26: ascii_base = 8'h33;  8'h25: ascii_base = 8'h34;  8'h2E: ascii_base = 8'h35;
      8'h36: ascii_base = 8'h36;  8'h3D: ascii_base = 8'h37;  8'h3E: ascii_base = 8'h38;
      8'h46: ascii_base = 8'h39;
      8'h29: ascii_base = 8'h20;  8'h5A: ascii_base = 8'h0D;  8'h66: ascii_base = 8'h08;
      default: ascii_base = 8'h00;
    endcase
  endfunction

  // Shifted digit row (US layout); everything else falls back to base.
  function automatic logic [7:0] ascii_shifted(input logic [7:0] sc);
    case (sc)
      8'h45: ascii_shifted = 8'h29;  8'h16: ascii_shifted = 8'h21;  8'h1E: ascii_shifted = 8'h40;
      8'h26: ascii_shifted = 8'h23;  8'h25: ascii_shifted = 8'h24;  8'h2E: ascii_shifted = 8'h25;
      8'h36: ascii_shifted = 8'h5E;  8'h3D: ascii_shifted = 8'h26;  8'h3E: ascii_shifted = 8'h2A;
      8'h46: ascii_shifted = 8'h28;
      default: ascii_shifted = ascii_base(sc);
    endcase
  endfunction

endpackage

// File: rtl/kbd_scancode_decoder_if.sv
// Key-event channel: valid/ready handshake carrying one decoded key event.
interface kbd_scancode_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_repeat;
  logic [7:0] evt_ascii;

  modport master (output evt_valid, evt_code, evt_ext, evt_break, evt_repeat, evt_ascii,
                  input  evt_ready);
  modport slave  (input  evt_valid, evt_code, evt_ext, evt_break, evt_repeat, evt_ascii,
                  output evt_ready);
endinterface

// File: rtl/kbd_scancode_decoder_ascii_map.sv
// Combinational set-2 scan code to ASCII using current shift/caps state.
module kbd_ascii_map
  import kbd_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);
  logic [7:0] base;

  assign base = ascii_base(code);

  always_comb begin
    if (base >= 8'h61 && base <= 8'h7A) ascii = (shift ^ caps) ? base - 8'd32 : base;
    else if (shift)                     ascii = ascii_shifted(code);
    else                                ascii = base;
  end
endmodule

// File: rtl/kbd_scancode_decoder.sv
// Pops PS/2 set-2 bytes from the receiver FIFO, folds E0/F0 prefixes and
// emits one key event per make/break with shift/caps/typematic tracking.
module kbd_scancode_decoder
  import kbd_pkg::*;
#(
  parameter bit IGNORE_CTRL = 1'b1
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic [7:0]                    kb_data,
  input  logic                          kb_ready,
  output logic                          kb_nextdata_n,
  kbd_scancode_decoder_if.master        evt,
  output logic                          shift,
  output logic                          caps,
  output logic [7:0]                    press_cnt
);
  kbd_state_e state;
  logic [7:0] byte_r, held_code, map_ascii;
  logic       ext_pend, brk_pend, held_vld, held_ext, lsh, rsh, evt_valid_q, same_key;
  kbd_evt_t   evt_q;

  kbd_ascii_map u_map (.code(byte_r), .shift(shift), .caps(caps), .ascii(map_ascii));

  assign shift    = lsh | rsh;
  assign same_key = held_vld && (held_ext == ext_pend) && (held_code == byte_r);

  assign evt.evt_valid  = evt_valid_q;
  assign evt.evt_code   = evt_q.code;
  assign evt.evt_ext    = evt_q.ext;
  assign evt.evt_break  = evt_q.brk;
  assign evt.evt_repeat = evt_q.rep;
  assign evt.evt_ascii  = evt_q.ascii;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state         <= ST_IDLE;
      kb_nextdata_n <= 1'b1;
      byte_r        <= '0;
      ext_pend      <= 1'b0;
      brk_pend      <= 1'b0;
      held_vld      <= 1'b0;
      held_ext      <= 1'b0;
      held_code     <= '0;
      lsh           <= 1'b0;
      rsh           <= 1'b0;
      caps          <= 1'b0;
      press_cnt     <= '0;
      evt_q         <= '0;
      evt_valid_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (kb_ready) begin
          kb_nextdata_n <= 1'b0;
          state         <= ST_ACK;
        end
        ST_ACK: begin
          kb_nextdata_n <= 1'b1;
          byte_r        <= kb_data;
          state         <= ST_DEC;
        end
        ST_DEC: begin
          state <= ST_IDLE;
          if (byte_r == SC_EXT) ext_pend <= 1'b1;
          else if (byte_r == SC_BRK) brk_pend <= 1'b1;
          else if (IGNORE_CTRL && is_ctrl(byte_r)) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end else begin
            // Translation sees shift/caps as they were before this byte.
            evt_q       <= '{code: byte_r, ext: ext_pend, brk: brk_pend,
                             rep: !brk_pend && same_key,
                             ascii: (brk_pend || ext_pend) ? 8'h00 : map_ascii};
            evt_valid_q <= 1'b1;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            state       <= ST_EMIT;
            if (!brk_pend) begin
              if (!same_key) begin
                held_vld  <= 1'b1;
                held_ext  <= ext_pend;
                held_code <= byte_r;
                press_cnt <= press_cnt + 8'd1;
                if (byte_r == SC_CAPS && !ext_pend) caps <= ~caps;
              end
              if (!ext_pend && byte_r == SC_LSHIFT) lsh <= 1'b1;
              if (!ext_pend && byte_r == SC_RSHIFT) rsh <= 1'b1;
            end else begin
              if (same_key) held_vld <= 1'b0;
              if (!ext_pend && byte_r == SC_LSHIFT) lsh <= 1'b0;
              if (!ext_pend && byte_r == SC_RSHIFT) rsh <= 1'b0;
            end
          end
        end
        ST_EMIT: if (evt.evt_ready) begin
          evt_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/kbd_scancode_decoder.md
# kbd_scancode_decoder

Consumes raw PS/2 set-2 scan-code bytes from the `ps2_keyboard` receiver FIFO and turns them into one key event per physical make or break. It pops bytes using the receiver's `ready`/`nextdata_n` protocol and folds the `E0` (extended) and `F0` (break) prefixes into flags. It tracks shift and caps-lock state, marks typematic repeats and translates to ASCII. Sits between `ps2_keyboard` and the display/console logic, which consumes events over a valid/ready handshake.

## Interface
- `IGNORE_CTRL`, default 1: when 1, device bytes `AA` (BAT ok), `FA` (ack), `FE`, `EE`, `00`, `FF` are popped and discarded.
- `clk` in 1: sole clock, rising edge.
- `clrn` in 1: reset, asynchronous, active-low.
- `kb_data` in 8: byte presented by the receiver, valid while `kb_ready`=1.
- `kb_ready` in 1: receiver FIFO non-empty.
- `kb_nextdata_n` out 1: active-low pop strobe to the receiver, exactly one cycle per byte.
- `evt_valid` out 1: event available.
- `evt_ready` in 1: consumer accepts the event.
- `evt_code` out 8: scan code without prefixes.
- `evt_ext` out 1: event was `E0`-prefixed.
- `evt_break` out 1: 1 = release, 0 = press.
- `evt_repeat` out 1: make of the key already held (typematic).
- `evt_ascii` out 8: ASCII for make events; 0 for breaks, extended keys and unmapped codes.
- `shift` out 1: either shift held (`12`, `59`, not extended).
- `caps` out 1: caps-lock latch.
- `press_cnt` out 8: count of non-repeat make events, wraps at 255→0.

## Operation
- **FSM states:** IDLE, ACK, DEC, EMIT.
- **IDLE:** if `kb_ready`, go to ACK.
- **ACK:** drive `kb_nextdata_n`=0, capture `kb_data` into `byte_r`, go to DEC.
- **DEC:** classify `byte_r`.
  - `E0`: set `ext_pend`, go to IDLE.
  - `F0`: set `brk_pend`, go to IDLE.
  - Control byte with `IGNORE_CTRL`=1: clear both pending flags, go to IDLE.
  - Otherwise: load the evt_* registers from `byte_r` and the pending flags, clear the pending flags, update state (below), go to EMIT.
- **EMIT:** `evt_valid`=1. Event fields stay stable until `evt_valid && evt_ready`, then go to IDLE. No bytes are popped while in EMIT; back-pressure accumulates in the receiver FIFO.
- **Held-key register:** `{held_vld, held_ext, held_code}`.
  - Make equal to the held key: `evt_repeat`=1, `press_cnt` unchanged.
  - Make of any other key: `evt_repeat`=0, the key becomes held, `press_cnt`+1.
  - Break matching the held key: clear `held_vld`.
- **Shift:** set on make, cleared on break of the left or right shift key. The left and right keys are tracked separately, and `shift` is their OR.
- **Caps:** toggles on a non-repeat make of `58`.
- **ASCII**, on non-extended makes only:
  - Letters: lowercase when `shift ^ caps` = 0, uppercase otherwise.
  - Digits `0–9`: the digit when `shift`=0; with `shift`=1, the US symbols `) ! @ # $ % ^ & * (`.
  - `29` → `20`, `5A` → `0D`, `66` → `08`.
  - All other codes → `00`.
  - Translation uses the shift/caps state from before the current byte's update.
- **Reset:** asynchronous and clears everything.
  - Outputs: `kb_nextdata_n`=1, `evt_valid`=0, all evt_* = 0, `shift`=`caps`=0, `press_cnt`=0.
  - Internal: held and pending flags 0, state IDLE.
  - A reset mid-prefix discards the prefix.

## Timing
- From `kb_ready` seen in IDLE (cycle 0): `kb_nextdata_n` low in cycle 1, `evt_valid` high from cycle 3.
- Prefix bytes cost 3 cycles each and produce no event.
- `kb_ready` is sampled only in IDLE. The receiver updates `ready` on the edge that ends ACK, so DEC/EMIT never see a stale `ready`.
- Minimum per event: 4 cycles, with `evt_ready` held at 1.
- `kb_nextdata_n` is registered: no glitch, and never low for two consecutive cycles.

## Structure
- Package `kbd_pkg` holds:
  - State enum.
  - Constants `SC_EXT=E0`, `SC_BRK=F0`, `SC_LSHIFT=12`, `SC_RSHIFT=59`, `SC_CAPS=58`.
  - Control-byte list.
  - Base and shifted ASCII lookup functions.
- One sub-module, `kbd_ascii_map`: purely combinational, `{code, shift, caps}` → ascii.

## Test plan
- **Single key:** `1C`, then `F0 1C`, `evt_ready`=1 → press event (code `1C`, ascii `61`, break 0, repeat 0, `press_cnt`=1), then release event (break 1, ascii `00`).
- **Shift and caps:**
  - Shift+A: `12 1C F0 1C F0 12` → A ascii `41`.
  - Caps toggle: `58 F0 58` sets `caps`=1; then `1C` → `41`; then `12 1C` → `61`.
- **Typematic:** `1C 1C 1C F0 1C` → repeat flags 0,1,1, `press_cnt`=1; a following `1C` → repeat 0, `press_cnt`=2.
- **Extended:** `E0 75`, then `E0 F0 75` → events ext=1, code `75`, ascii `00`, with break 0 then 1; `shift`/`caps` unchanged.
- **Back-pressure:** preload `16 F0 16 AA`, hold `evt_ready`=0 for 20 cycles → exactly one `kb_nextdata_n` pulse. After release: events `16` (ascii `31`) then break `16`; `AA` popped with no event.
- **Reset:** assert `clrn`=0 between `E0` and `75` → all outputs at reset values immediately. After release, `75` yields ext=0.
